// File: rtl/conv_pkg.sv
// Shared types and constants for the layer-memory datapath.
// Widths, layer select codes and the arbiter state encoding.
package conv_pkg;

  localparam int AW = 12;
  localparam int DW = 20;
  localparam int SW = 3;

  localparam logic [SW-1:0] CSEL_NONE = 3'b000;
  localparam logic [SW-1:0] CSEL_L0   = 3'b001;
  localparam logic [SW-1:0] CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid + owner-tag delay line that follows each crd strobe
// so read data can be steered back to the requester that issued it.
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_vld,
  input  logic in_tag,
  output logic out_vld,
  output logic out_tag
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] tag;

  // Shift valid and tag one stage per cycle; reset drops in-flight reads
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      tag <= '0;
    end else begin
      vld[0] <= in_vld;
      tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_vld = vld[DEPTH-1];
  assign out_tag = tag[DEPTH-1];

endmodule

// File: rtl/layer_mem_arbiter.sv
// Two-requester arbiter for the single layer-memory port.
// Define ARB_PERF_EN to add the wait_cnt0/wait_cnt1 stall counters.
module layer_mem_arbiter #(
  parameter int AW       = conv_pkg::AW,
  parameter int DW       = conv_pkg::DW,
  parameter int SW       = conv_pkg::SW,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           rq_req,
  input  logic [1:0]           rq_we,
  input  logic [1:0][AW-1:0]   rq_addr,
  input  logic [1:0][DW-1:0]   rq_wdata,
  input  logic [1:0][SW-1:0]   rq_sel,
  input  logic [1:0]           rq_lock,
  output logic [1:0]           rq_gnt,
  output logic [1:0]           rq_rvalid,
  output logic [DW-1:0]        rq_rdata,
`ifdef ARB_PERF_EN
  output logic [15:0]          wait_cnt0,
  output logic [15:0]          wait_cnt1,
`endif
  output logic                 cwr,
  output logic                 crd,
  output logic [AW-1:0]        caddr_wr,
  output logic [AW-1:0]        caddr_rd,
  output logic [DW-1:0]        cdata_wr,
  input  logic [DW-1:0]        cdata_rd,
  output logic [SW-1:0]        csel
);

  import conv_pkg::*;

  arb_state_t state, state_nxt;
  logic       rr_last, rr_nxt;
  logic [4:0] lock_cnt, cnt_nxt;
  logic       win, acc;
  logic       rd_tag;
  logic       pv, pt;

  // Grant selection and next ownership state
  always_comb begin
    rq_gnt    = '0;
    state_nxt = state;
    rr_nxt    = rr_last;
    cnt_nxt   = lock_cnt;
    win       = 1'b0;
    acc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|rq_req) begin
          acc = 1'b1;
          if (&rq_req) begin
            win    = ~rr_last;
            rr_nxt = win;
          end else begin
            win = rq_req[1];
          end
          if (rq_lock[win]) begin
            state_nxt = win ? OWN1 : OWN0;
            cnt_nxt   = 5'd1;
          end
        end
      end
      default: begin
        win = (state == OWN1);
        if (rq_req[win]) begin
          acc     = 1'b1;
          cnt_nxt = lock_cnt + {4'd0, ~&lock_cnt};
          if (!rq_lock[win]) begin
            state_nxt = IDLE;
          end else if (rq_req[~win] &&
                       ({1'b0, lock_cnt} + 6'd1)
                       >= 6'(MAX_LOCK)) begin
            state_nxt = IDLE;
            rr_nxt    = win;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
    rq_gnt[win] = acc;
  end

  // Ownership state, round-robin pointer and lock counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  // Registered memory command; fields hold when no beat is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      csel     <= '0;
      rd_tag   <= 1'b0;
    end else begin
      cwr <= acc & rq_we[win];
      crd <= acc & ~rq_we[win];
      if (acc) begin
        csel <= rq_sel[win];
        if (rq_we[win]) begin
          caddr_wr <= rq_addr[win];
          cdata_wr <= rq_wdata[win];
        end else begin
          caddr_rd <= rq_addr[win];
          rd_tag   <= win;
        end
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (crd),
    .in_tag  (rd_tag),
    .out_vld (pv),
    .out_tag (pt)
  );

  assign rq_rvalid = {pv & pt, pv & ~pt};
  assign rq_rdata  = pv ? cdata_rd : '0;

`ifdef ARB_PERF_EN
  // Saturating count of cycles each requester waits ungranted
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt0 <= '0;
      wait_cnt1 <= '0;
    end else begin
      if (rq_req[0] && !rq_gnt[0] && !(&wait_cnt0))
        wait_cnt0 <= wait_cnt0 + 16'd1;
      if (rq_req[1] && !rq_gnt[1] && !(&wait_cnt1))
        wait_cnt1 <= wait_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench for layer_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model (RD_LAT=1 main DUT, RD_LAT=3 second DUT).
module tb_layer_mem_arbiter;

  import conv_pkg::*;

  localparam int RD_LAT   = 1;
  localparam int MAX_LOCK = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [1:0]          rq_req, rq_we, rq_lock;
  logic [1:0][AW-1:0]  rq_addr;
  logic [1:0][DW-1:0]  rq_wdata;
  logic [1:0][SW-1:0]  rq_sel;
  logic [1:0]          rq_gnt, rq_rvalid;
  logic [DW-1:0]       rq_rdata, cdata_wr, cdata_rd;
  logic                cwr, crd;
  logic [AW-1:0]       caddr_wr, caddr_rd;
  logic [SW-1:0]       csel;
  logic [15:0]         wait_cnt0, wait_cnt1;

  logic                b_reset;
  logic [1:0]          b_req, b_we, b_lock;
  logic [1:0][AW-1:0]  b_addr;
  logic [1:0][DW-1:0]  b_wdata;
  logic [1:0][SW-1:0]  b_sel;
  logic [1:0]          b_gnt, b_rvalid;
  logic [DW-1:0]       b_rdata, b_cdw, b_cdr;
  logic                b_cwr, b_crd;
  logic [AW-1:0]       b_caw, b_car;
  logic [SW-1:0]       b_csel;
  logic [15:0]         b_w0, b_w1;

  layer_mem_arbiter #(
    .RD_LAT   (RD_LAT),
    .MAX_LOCK (MAX_LOCK)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .rq_req    (rq_req),
    .rq_we     (rq_we),
    .rq_addr   (rq_addr),
    .rq_wdata  (rq_wdata),
    .rq_sel    (rq_sel),
    .rq_lock   (rq_lock),
    .rq_gnt    (rq_gnt),
    .rq_rvalid (rq_rvalid),
    .rq_rdata  (rq_rdata),
`ifdef ARB_PERF_EN
    .wait_cnt0 (wait_cnt0),
    .wait_cnt1 (wait_cnt1),
`endif
    .cwr       (cwr),
    .crd       (crd),
    .caddr_wr  (caddr_wr),
    .caddr_rd  (caddr_rd),
    .cdata_wr  (cdata_wr),
    .cdata_rd  (cdata_rd),
    .csel      (csel)
  );

  layer_mem_arbiter #(
    .RD_LAT   (3),
    .MAX_LOCK (MAX_LOCK)
  ) u_dut3 (
    .clk       (clk),
    .reset     (b_reset),
    .rq_req    (b_req),
    .rq_we     (b_we),
    .rq_addr   (b_addr),
    .rq_wdata  (b_wdata),
    .rq_sel    (b_sel),
    .rq_lock   (b_lock),
    .rq_gnt    (b_gnt),
    .rq_rvalid (b_rvalid),
    .rq_rdata  (b_rdata),
`ifdef ARB_PERF_EN
    .wait_cnt0 (b_w0),
    .wait_cnt1 (b_w1),
`endif
    .cwr       (b_cwr),
    .crd       (b_crd),
    .caddr_wr  (b_caw),
    .caddr_rd  (b_car),
    .cdata_wr  (b_cdw),
    .cdata_rd  (b_cdr),
    .csel      (b_csel)
  );

`ifndef ARB_PERF_EN
  assign wait_cnt0 = '0;
  assign wait_cnt1 = '0;
  assign b_w0 = '0;
  assign b_w1 = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference model
  typedef struct {
    int due;
    bit tag;
  } rd_t;

  rd_t           rdq[$];
  int            m_owner, m_cnt, m_win, cyc;
  bit            m_rr;
  int            m_w0, m_w1;
  logic          m_cwr, m_crd;
  logic [AW-1:0] m_caw, m_car;
  logic [DW-1:0] m_cdw;
  logic [SW-1:0] m_csel;
  logic [1:0]    e_gnt, e_rv;
  logic [DW-1:0] e_rdata;

  function automatic logic [72:0] act_vec();
    return {rq_gnt, rq_rvalid, rq_rdata, cwr, crd,
            caddr_wr, caddr_rd, cdata_wr, csel};
  endfunction

  function automatic logic [72:0] exp_vec();
    return {e_gnt, e_rv, e_rdata, m_cwr, m_crd,
            m_caw, m_car, m_cdw, m_csel};
  endfunction

  task automatic model_eval();
    int w;
    w = -1;
    if (m_owner >= 0) begin
      if (rq_req[m_owner]) w = m_owner;
    end else if (rq_req == 2'b11) begin
      w = m_rr ? 0 : 1;
    end else if (rq_req[0]) begin
      w = 0;
    end else if (rq_req[1]) begin
      w = 1;
    end
    m_win = w;
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    e_rv = '0;
    e_rdata = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e_rv[rdq[0].tag] = 1'b1;
      e_rdata = cdata_rd;
    end
  endtask

  task automatic model_commit();
    int w;
    if (reset) begin
      rdq.delete();
      m_owner = -1; m_cnt = 0; m_rr = 1'b1;
      m_w0 = 0; m_w1 = 0;
      m_cwr = 0; m_crd = 0; m_caw = '0; m_car = '0;
      m_cdw = '0; m_csel = '0;
      cyc++;
      return;
    end
    if (rq_req[0] && !e_gnt[0] && m_w0 < 65535) m_w0++;
    if (rq_req[1] && !e_gnt[1] && m_w1 < 65535) m_w1++;
    if (rdq.size() > 0 && rdq[0].due == cyc) void'(rdq.pop_front());
    m_cwr = 0;
    m_crd = 0;
    w = m_win;
    if (w >= 0) begin
      m_csel = rq_sel[w];
      if (rq_we[w]) begin
        m_cwr = 1; m_caw = rq_addr[w]; m_cdw = rq_wdata[w];
      end else begin
        m_crd = 1; m_car = rq_addr[w];
        rdq.push_back('{cyc + 1 + RD_LAT, bit'(w)});
      end
      if (m_owner < 0) begin
        if (rq_req == 2'b11) m_rr = bit'(w);
        if (rq_lock[w]) begin
          m_owner = w;
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (!rq_lock[w]) m_owner = -1;
        else if (rq_req[1-w] && m_cnt >= MAX_LOCK) begin
          m_owner = -1;
          m_rr = bit'(w);
        end
      end
    end else if (m_owner >= 0) begin
      m_owner = -1;
    end
    cyc++;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; b_reset = 1;
    rq_req = '0; b_req = '0;
    repeat (2) begin
      settle();
      advance();
    end
    reset = 0; b_reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_cmp++;
    if (act_vec() !== 73'd0) begin
      n_bad++;
      $display("FAIL reset_outs act=%h exp=0", act_vec());
    end
    n_cmp++;
    if ({wait_cnt0, wait_cnt1} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_wait act=%h exp=0", {wait_cnt0, wait_cnt1});
    end
    advance();
  endtask

  task automatic test_single_read();
    do_reset();
    rq_req = 2'b01; rq_we = 2'b00; rq_lock = 2'b00;
    rq_addr[0] = 12'h041; rq_sel[0] = CSEL_L0;
    cdata_rd = 20'h12345;
    settle();
    n_cmp++;
    if (rq_gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL rd_gnt act=%b exp=01", rq_gnt);
    end
    advance();
    rq_req = 2'b00;
    settle();
    n_cmp++;
    if ({crd, cwr, caddr_rd, csel} !== {2'b10, 12'h041, CSEL_L0}) begin
      n_bad++;
      $display("FAIL rd_strobe act=%b/%b/%h/%b exp=1/0/041/001",
               crd, cwr, caddr_rd, csel);
    end
    advance();
    cdata_rd = 20'hABCDE;
    settle();
    n_cmp++;
    if ({rq_rvalid, rq_rdata} !== {2'b01, 20'hABCDE}) begin
      n_bad++;
      $display("FAIL rd_ret act=%b/%h exp=01/abcde", rq_rvalid, rq_rdata);
    end
    advance();
    settle();
    n_cmp++;
    if ({rq_rvalid, crd} !== 3'b000) begin
      n_bad++;
      $display("FAIL rd_pulse act=%b/%b exp=00/0", rq_rvalid, crd);
    end
    advance();
  endtask

  task automatic test_tie();
    logic [1:0] eg;
    logic [SW-1:0] es;
    do_reset();
    rq_req = 2'b11; rq_we = 2'b11; rq_lock = 2'b00;
    rq_addr[0] = 12'h010; rq_addr[1] = 12'h020;
    rq_wdata[0] = 20'h11111; rq_wdata[1] = 20'h22222;
    rq_sel[0] = CSEL_L0; rq_sel[1] = CSEL_L1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) rq_req = 2'b00;
      settle();
      if (k < 4) begin
        eg = k[0] ? 2'b10 : 2'b01;
        n_cmp++;
        if (rq_gnt !== eg) begin
          n_bad++;
          $display("FAIL tie_gnt%0d act=%b exp=%b", k, rq_gnt, eg);
        end
      end
      if (k > 0) begin
        es = k[0] ? CSEL_L0 : CSEL_L1;
        n_cmp++;
        if ({cwr, crd, csel} !== {2'b10, es}) begin
          n_bad++;
          $display("FAIL tie_wr%0d act=%b%b/%b exp=10/%b",
                   k, cwr, crd, csel, es);
        end
      end
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL tie_vec%0d act=%h exp=%h", k, act_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_lock();
    logic [AW-1:0] al [4];
    logic [1:0] eg, ev;
    int idx;
    al = '{12'd0, 12'd1, 12'd64, 12'd65};
    do_reset();
    idx = 0;
    rq_we = 2'b01;
    rq_sel[0] = CSEL_L1; rq_sel[1] = CSEL_L0;
    rq_addr[0] = 12'h7ff; rq_wdata[0] = 20'h0beef;
    for (int c = 0; c < 9; c++) begin
      rq_req[0] = (c >= 1);
      rq_req[1] = (idx < 4);
      rq_lock[0] = 1'b0;
      rq_lock[1] = (idx < 3);
      rq_addr[1] = al[idx % 4];
      cdata_rd = 20'($urandom);
      settle();
      eg = (c < 4) ? 2'b10 : 2'b01;
      ev = (c >= 2 && c <= 5) ? 2'b10 : 2'b00;
      n_cmp++;
      if (rq_gnt !== eg) begin
        n_bad++;
        $display("FAIL lock_gnt%0d act=%b exp=%b", c, rq_gnt, eg);
      end
      n_cmp++;
      if ({rq_rvalid, rq_rdata} !== {ev, ev[1] ? cdata_rd : 20'd0}) begin
        n_bad++;
        $display("FAIL lock_rv%0d act=%b/%h exp=%b", c, rq_rvalid,
                 rq_rdata, ev);
      end
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL lock_vec%0d act=%h exp=%h", c, act_vec(), exp_vec());
      end
      if (eg[1]) idx++;
      advance();
    end
    rq_req = '0;
  endtask

  task automatic test_starve();
    logic [1:0] eg;
    int beats;
    bit done1;
    do_reset();
    beats = 0; done1 = 0;
    rq_we = 2'b11; rq_lock = 2'b01;
    rq_sel[0] = CSEL_L0; rq_sel[1] = CSEL_L1;
    for (int c = 0; c < 44; c++) begin
      rq_req[0] = (beats < 40);
      rq_req[1] = !done1;
      rq_addr[0] = 12'(c); rq_wdata[0] = 20'(c);
      rq_addr[1] = 12'h800; rq_wdata[1] = 20'hfffff;
      settle();
      if (c < 16) eg = 2'b01;
      else if (c == 16) eg = 2'b10;
      else if (c <= 40) eg = 2'b01;
      else eg = 2'b00;
      n_cmp++;
      if (rq_gnt !== eg) begin
        n_bad++;
        $display("FAIL starve_gnt%0d act=%b exp=%b", c, rq_gnt, eg);
      end
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL starve_vec%0d act=%h exp=%h", c, act_vec(),
                 exp_vec());
      end
      if (eg[0]) beats++;
      if (eg[1]) done1 = 1;
      advance();
    end
    rq_req = '0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    b_req = 2'b01; b_we = 2'b00; b_lock = 2'b00;
    b_addr[0] = 12'h123; b_sel[0] = CSEL_L0;
    b_cdr = 20'h5a5a5;
    settle();
    n_cmp++;
    if (b_gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_gnt act=%b exp=01", b_gnt);
    end
    advance();
    b_req = 2'b00;
    settle();
    n_cmp++;
    if (b_crd !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_crd act=%b exp=1", b_crd);
    end
    advance();
    b_reset = 1;
    settle();
    advance();
    b_reset = 0;
    for (int c = 3; c < 8; c++) begin
      settle();
      if (c == 3) begin
        n_cmp++;
        if ({b_gnt, b_rvalid, b_rdata, b_cwr, b_crd, b_caw, b_car,
             b_cdw, b_csel, b_w0, b_w1} !== 105'd0) begin
          n_bad++;
          $display("FAIL mid_zero act=%b%b/%h/%b%b/%h/%h/%h/%b",
                   b_gnt, b_rvalid, b_rdata, b_cwr, b_crd, b_caw,
                   b_car, b_cdw, b_csel);
        end
      end
      n_cmp++;
      if (b_rvalid !== 2'b00) begin
        n_bad++;
        $display("FAIL mid_rv%0d act=%b exp=00", c, b_rvalid);
      end
      advance();
    end
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    rq_we = 2'b11;
    rq_sel[0] = CSEL_L0; rq_sel[1] = CSEL_L1;
    for (int c = 0; c < 7; c++) begin
      rq_req[0] = (c < 5);
      rq_lock[0] = (c < 4);
      rq_req[1] = (c <= 5);
      rq_lock[1] = 1'b0;
      settle();
      if (c == 6) begin
        n_cmp++;
        if ({wait_cnt0, wait_cnt1} !== {16'd0, 16'd5}) begin
          n_bad++;
          $display("FAIL perf_wait act=%0d/%0d exp=0/5",
                   wait_cnt0, wait_cnt1);
        end
      end
      advance();
    end
    rq_req = '0;
  endtask
`endif

  task automatic test_random();
    logic [1:0] hold;
    do_reset();
    hold = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          rq_req[i]   = ($urandom_range(0, 3) != 0);
          rq_we[i]    = 1'($urandom);
          rq_lock[i]  = ($urandom_range(0, 3) != 0);
          rq_addr[i]  = AW'($urandom);
          rq_wdata[i] = DW'($urandom);
          rq_sel[i]   = SW'($urandom);
        end
      end
      cdata_rd = DW'($urandom);
      settle();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rand_vec%0d act=%h exp=%h", c, act_vec(), exp_vec());
      end
`ifdef ARB_PERF_EN
      n_cmp++;
      if ({wait_cnt0, wait_cnt1} !== {16'(m_w0), 16'(m_w1)}) begin
        n_bad++;
        $display("FAIL rand_wait%0d act=%0d/%0d exp=%0d/%0d", c,
                 wait_cnt0, wait_cnt1, m_w0, m_w1);
      end
`endif
      hold = rq_req & ~e_gnt;
      advance();
    end
    rq_req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; b_reset = 1;
    rq_req = '0; rq_we = '0; rq_lock = '0;
    rq_addr = '0; rq_wdata = '0; rq_sel = '0;
    b_req = '0; b_we = '0; b_lock = '0;
    b_addr = '0; b_wdata = '0; b_sel = '0;
    cdata_rd = '0; b_cdr = '0;
    m_owner = -1; m_cnt = 0; m_rr = 1; m_win = -1; cyc = 0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_tie();
    test_lock();
    test_starve();
    test_reset_mid_read();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
